// File: rtl/axis_pixel_repeat_pkg.sv
// Shared constants and beat types for the pixel input pipe and the
// pixel repeater.
//   UNITS        pixel words per stream per beat
//   WORD_WIDTH   bits per pixel word
//   BITS_REPEAT  width of the copies-per-beat-minus-1 config
//   BITS_BEATS   width of the beats-per-block-minus-1 config
package axis_pixel_repeat_pkg;

  localparam int UNITS       = 2;
  localparam int WORD_WIDTH  = 8;
  localparam int BITS_REPEAT = 4;
  localparam int BITS_BEATS  = 16;
  localparam int BEAT_WIDTH  = UNITS * WORD_WIDTH;

  typedef logic [WORD_WIDTH-1:0] pixel_word_t;

  // One paired, shift-aligned beat: stream 1 and stream 2 side by side.
  typedef struct packed {
    pixel_word_t [UNITS-1:0] pixels_1;
    pixel_word_t [UNITS-1:0] pixels_2;
  } pixel_pair_t;

endpackage

// File: rtl/axis_pixel_repeat_if.sv
// Paired-pixel AXI-Stream bundle: one valid/ready handshake covering
// both pixel streams, plus tlast on the producer side.
//   tvalid/tready   handshake; a beat moves on a cycle where both are 1.
//                   The producer holds tvalid, data and tlast stable until
//                   the beat is taken; tready may never depend on tvalid.
//   tlast           end of block (driven only by the repeater output)
//   pixels_1_tdata  stream-1 pixels, UNITS words
//   pixels_2_tdata  stream-2 pixels, UNITS words
interface axis_pixel_repeat_if;
  import axis_pixel_repeat_pkg::*;

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [BEAT_WIDTH-1:0] pixels_1_tdata;
  logic [BEAT_WIDTH-1:0] pixels_2_tdata;

  modport master (
    output tvalid, tlast, pixels_1_tdata, pixels_2_tdata,
    input  tready
  );

  // Upstream beats carry no block marker, so the consumer side omits tlast.
  modport slave (
    input  tvalid, pixels_1_tdata, pixels_2_tdata,
    output tready
  );

endinterface

// File: rtl/axis_pixel_repeat_ctrl.sv
// Control for the pixel repeater: copy counter, beat-in-block counter,
// block-active flag, latched repeat config, registered valid and tlast.
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_repeat_1_i     copies per beat minus 1 (sampled at block start)
//   cfg_beats_1_i      beats per block minus 1 (sampled at block start)
//   s_valid_i/s_ready_o  upstream handshake
//   m_ready_i/m_valid_o  downstream handshake, m_last_o = tlast
//   load_o             data registers capture the upstream beat
module axis_pixel_repeat_ctrl
  import axis_pixel_repeat_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BITS_REPEAT-1:0] cfg_repeat_1_i,
  input  logic [BITS_BEATS-1:0]  cfg_beats_1_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_last_o,
  output logic                   load_o
);

  logic [BITS_REPEAT-1:0] rep_cnt_q, rep_cnt_d;
  logic [BITS_REPEAT-1:0] rep_lat_q, rep_lat_d;
  logic [BITS_BEATS-1:0]  beat_cnt_q, beat_cnt_d;
  logic                   blk_active_q, blk_active_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  logic last_copy;
  logic out_hs;
  logic in_hs;

  assign last_copy = (rep_cnt_q == '0);
  assign out_hs    = valid_q & m_ready_i;
  // A new beat fits when the output is empty or its final copy leaves now.
  assign s_ready_o = ~valid_q | (m_ready_i & last_copy);
  assign in_hs     = s_valid_i & s_ready_o;

  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    rep_lat_d    = rep_lat_q;
    beat_cnt_d   = beat_cnt_q;
    blk_active_d = blk_active_q;
    valid_d      = valid_q;

    if (out_hs) begin
      if (!last_copy) rep_cnt_d = rep_cnt_q - 1'b1;
      else            valid_d   = 1'b0;
      if (last_q)     blk_active_d = 1'b0;
    end

    if (in_hs) begin
      valid_d = 1'b1;
      // A block finishing in this same cycle counts as inactive, so the
      // incoming beat opens the next block and samples the live config.
      if (!blk_active_q || (out_hs && last_q)) begin
        rep_lat_d    = cfg_repeat_1_i;
        beat_cnt_d   = cfg_beats_1_i;
        rep_cnt_d    = cfg_repeat_1_i;
        blk_active_d = 1'b1;
      end else begin
        if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - 1'b1;
        rep_cnt_d = rep_lat_q;
      end
    end

    // tlast is computed from next state so it is a clean register output.
    last_d = valid_d & (rep_cnt_d == '0) & (beat_cnt_d == '0) & blk_active_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt_q    <= '0;
      rep_lat_q    <= '0;
      beat_cnt_q   <= '0;
      blk_active_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      rep_lat_q    <= rep_lat_d;
      beat_cnt_q   <= beat_cnt_d;
      blk_active_q <= blk_active_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;
  assign load_o    = in_hs;

endmodule

// File: rtl/axis_pixel_repeat.sv
// Pixel repeater: accepts paired pixel beats and re-emits each one
// (cfg_repeat_1+1) times, marking the final copy of the final beat of each
// (cfg_beats_1+1)-beat block with tlast. Registered output, one output per
// cycle at any repeat count.
//   aclk, areset     clock, synchronous active-high reset
//   cfg_repeat_1     copies per beat minus 1
//   cfg_beats_1      input beats per block minus 1
//   s_axis           upstream paired-pixel stream (slave)
//   m_axis           repeated paired-pixel stream with tlast (master)
module axis_pixel_repeat
  import axis_pixel_repeat_pkg::*;
(
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [BITS_REPEAT-1:0] cfg_repeat_1,
  input  logic [BITS_BEATS-1:0]  cfg_beats_1,
  axis_pixel_repeat_if.slave     s_axis,
  axis_pixel_repeat_if.master    m_axis
);

  pixel_pair_t data_q;
  logic        load;

  axis_pixel_repeat_ctrl u_ctrl (
    .clk_i          (aclk),
    .rst_i          (areset),
    .cfg_repeat_1_i (cfg_repeat_1),
    .cfg_beats_1_i  (cfg_beats_1),
    .s_valid_i      (s_axis.tvalid),
    .s_ready_o      (s_axis.tready),
    .m_ready_i      (m_axis.tready),
    .m_valid_o      (m_axis.tvalid),
    .m_last_o       (m_axis.tlast),
    .load_o         (load)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      data_q <= '0;
    end else if (load) begin
      data_q.pixels_1 <= s_axis.pixels_1_tdata;
      data_q.pixels_2 <= s_axis.pixels_2_tdata;
    end
  end

  assign m_axis.pixels_1_tdata = data_q.pixels_1;
  assign m_axis.pixels_2_tdata = data_q.pixels_2;

endmodule

// File: tb/tb_axis_pixel_repeat.sv
module tb_axis_pixel_repeat;

  logic        aclk;
  logic        areset;
  logic [3:0]  cfg_repeat_1;
  logic [15:0] cfg_beats_1;

  axis_pixel_repeat_if s_if ();
  axis_pixel_repeat_if m_if ();

  axis_pixel_repeat dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_repeat_1 (cfg_repeat_1),
    .cfg_beats_1  (cfg_beats_1),
    .s_axis       (s_if),
    .m_axis       (m_if)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // {tlast, pixels_1, pixels_2}
  logic [31:0] send_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          obs_cyc_q[$];
  int          acc_q[$];
  logic        rdy_q[$];
  int          stall_err;

  // Driver: runs the upstream queue against a downstream ready pattern,
  // recording accepted beats, output handshakes and upstream ready per
  // cycle. Entered and left at 1 time unit after a rising edge (except on
  // an early stop, where it returns mid-cycle with inputs still applied).
  task automatic run(input int max_cyc, input logic [15:0] pat, input int plen,
                     input int stop_outs, input int chg_cyc, input logic [3:0] chg_val,
                     output bit timed_out);
    logic        stalled;
    logic [32:0] held, cur;
    bit          acc;
    obs_q.delete(); obs_cyc_q.delete(); acc_q.delete(); rdy_q.delete();
    stall_err = 0;
    timed_out = 1'b1;
    stalled   = 1'b0;
    held      = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc == chg_cyc) cfg_repeat_1 = chg_val;
      m_if.tready = pat[cyc % plen];
      s_if.tvalid = (send_q.size() > 0);
      if (send_q.size() > 0) {s_if.pixels_1_tdata, s_if.pixels_2_tdata} = send_q[0];
      #1;
      cur = {m_if.tlast, m_if.pixels_1_tdata, m_if.pixels_2_tdata};
      if (stalled && (m_if.tvalid !== 1'b1 || cur !== held)) stall_err++;
      stalled = m_if.tvalid & ~m_if.tready;
      held    = cur;
      rdy_q.push_back(s_if.tready);
      acc = s_if.tvalid && s_if.tready;
      if (acc) begin
        void'(send_q.pop_front());
        acc_q.push_back(cyc);
      end
      if (m_if.tvalid && m_if.tready) begin
        obs_q.push_back(cur);
        obs_cyc_q.push_back(cyc);
      end
      if (stop_outs > 0 && obs_q.size() >= stop_outs) begin
        timed_out = 1'b0;
        break;
      end
      if (stop_outs == 0 && send_q.size() == 0 && !m_if.tvalid && !acc) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge aclk); #1;
    end
    if (stop_outs == 0) begin
      s_if.tvalid = 1'b0;
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.pixels_1_tdata = 16'hFFFF;
    s_if.pixels_2_tdata = 16'hFFFF;
    m_if.tready = 1'b1;
    cfg_repeat_1 = '0;
    cfg_beats_1  = '0;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", m_if.tvalid); end
    n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b want 0", m_if.tlast); end
    n_cmp++; if ({m_if.pixels_1_tdata, m_if.pixels_2_tdata} !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", {m_if.pixels_1_tdata, m_if.pixels_2_tdata}); end
    areset = 1'b0;
    @(posedge aclk); #1;
    n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL rst_sready got %b want 1", s_if.tready); end
  endtask

  task automatic test_repeat3();
    bit to;
    logic [5:0] rtr;
    cfg_repeat_1 = 4'd2; cfg_beats_1 = 16'd1;
    send_q = '{32'hA1A2_A3A4, 32'hB1B2_B3B4};
    exp_q  = '{{1'b0, 32'hA1A2_A3A4}, {1'b0, 32'hA1A2_A3A4}, {1'b0, 32'hA1A2_A3A4},
               {1'b0, 32'hB1B2_B3B4}, {1'b0, 32'hB1B2_B3B4}, {1'b1, 32'hB1B2_B3B4}};
    run(60, 16'hFFFF, 1, 0, -1, 4'd0, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL r3_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL r3_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL r3_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      n_cmp++; if (obs_cyc_q[i] !== i + 1) begin n_err++; $display("FAIL r3_cycle[%0d] got %0d want %0d", i, obs_cyc_q[i], i + 1); end
    end
    rtr = 'x;
    for (int i = 0; i < 6 && i < rdy_q.size(); i++) rtr[i] = rdy_q[i];
    n_cmp++; if (rtr !== 6'b001001) begin n_err++; $display("FAIL r3_sready_trace got %b want 001001", rtr); end
    n_cmp++; if (acc_q.size() !== 2 || acc_q[0] !== 0 || acc_q[1] !== 3) begin n_err++; $display("FAIL r3_accept_cycles got n=%0d want 0,3", acc_q.size()); end
  endtask

  task automatic test_no_repeat();
    bit to;
    int zeros;
    cfg_repeat_1 = 4'd0; cfg_beats_1 = 16'd3;
    send_q = '{32'h0101_1010, 32'h0202_2020, 32'h0303_3030, 32'h0404_4040};
    exp_q  = '{{1'b0, 32'h0101_1010}, {1'b0, 32'h0202_2020}, {1'b0, 32'h0303_3030}, {1'b1, 32'h0404_4040}};
    run(60, 16'hFFFF, 1, 0, -1, 4'd0, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL r1_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL r1_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL r1_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      n_cmp++; if (obs_cyc_q[i] !== i + 1) begin n_err++; $display("FAIL r1_cycle[%0d] got %0d want %0d", i, obs_cyc_q[i], i + 1); end
    end
    zeros = 0;
    foreach (rdy_q[i]) if (rdy_q[i] !== 1'b1) zeros++;
    n_cmp++; if (zeros !== 0) begin n_err++; $display("FAIL r1_sready_drops got %0d want 0", zeros); end
  endtask

  task automatic test_stall();
    bit to;
    cfg_repeat_1 = 4'd1; cfg_beats_1 = 16'd2;
    send_q = '{32'hC0C1_C2C3, 32'hD0D1_D2D3, 32'hE0E1_E2E3};
    exp_q  = '{{1'b0, 32'hC0C1_C2C3}, {1'b0, 32'hC0C1_C2C3}, {1'b0, 32'hD0D1_D2D3},
               {1'b0, 32'hD0D1_D2D3}, {1'b0, 32'hE0E1_E2E3}, {1'b1, 32'hE0E1_E2E3}};
    run(100, 16'b1001, 4, 0, -1, 4'd0, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL stall_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL stall_stability got %0d changes want 0", stall_err); end
  endtask

  task automatic test_cfg_change();
    bit to;
    logic [31:0] b[6];
    cfg_repeat_1 = 4'd1; cfg_beats_1 = 16'd2;
    for (int i = 0; i < 6; i++) b[i] = 32'h5500_0000 + 32'(i * 16'h0111);
    send_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) send_q.push_back(b[i]);
    // First block was sampled with 2 copies per beat, second with 4.
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) exp_q.push_back({(i == 2 && c == 1), b[i]});
    for (int i = 3; i < 6; i++)
      for (int c = 0; c < 4; c++) exp_q.push_back({(i == 5 && c == 3), b[i]});
    run(200, 16'hFFFF, 1, 0, 1, 4'd3, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL cfg_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL cfg_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cfg_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    cfg_repeat_1 = 4'd2; cfg_beats_1 = 16'd1;
    send_q = '{32'h1111_2222, 32'h3333_4444};
    run(60, 16'hFFFF, 1, 3, -1, 4'd0, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL mrst_timeout got %b want 0", to); end
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    send_q.delete();
    @(posedge aclk); #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b want 0", m_if.tvalid); end
    n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL mrst_tlast got %b want 0", m_if.tlast); end
    n_cmp++; if ({m_if.pixels_1_tdata, m_if.pixels_2_tdata} !== 32'h0) begin n_err++; $display("FAIL mrst_data got %h want 0", {m_if.pixels_1_tdata, m_if.pixels_2_tdata}); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL mrst_sready got %b want 1", s_if.tready); end
    areset = 1'b0;
    @(posedge aclk); #1;
    cfg_repeat_1 = 4'd1; cfg_beats_1 = 16'd0;
    send_q = '{32'h7777_8888};
    exp_q  = '{{1'b0, 32'h7777_8888}, {1'b1, 32'h7777_8888}};
    run(60, 16'hFFFF, 1, 0, -1, 4'd0, to);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mrst_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    cfg_repeat_1 = 4'd1; cfg_beats_1 = 16'd0;
    send_q = '{32'h9A9A_0001, 32'hBCBC_0002};
    exp_q  = '{{1'b0, 32'h9A9A_0001}, {1'b1, 32'h9A9A_0001}, {1'b0, 32'hBCBC_0002}, {1'b1, 32'hBCBC_0002}};
    run(60, 16'hFFFF, 1, 0, -1, 4'd0, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      n_cmp++; if (obs_cyc_q[i] !== i + 1) begin n_err++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, obs_cyc_q[i], i + 1); end
    end
    n_cmp++; if (acc_q.size() !== 2 || acc_q[0] !== 0 || acc_q[1] !== 2) begin n_err++; $display("FAIL b2b_accept_cycles got n=%0d want 0,2", acc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_repeat3();
    test_no_repeat();
    test_stall();
    test_cfg_change();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pixel_repeat.md
Name: axis_pixel_repeat

Overview:
- Sits directly downstream of the input pipe. Consumes the paired, shift-aligned pixel beats (pixels_1/pixels_2, UNITS words each) on one shared valid/ready handshake.
- Re-emits each accepted beat a configurable number of times, one copy per kernel column/core pass, and marks block boundaries with tlast.
- Registered output, full throughput: a new beat is accepted in the same cycle the last copy of the previous beat is handed off.

Parameters:
- UNITS, 2, pixel words per stream per beat
- WORD_WIDTH, 8, bits per pixel word
- BITS_REPEAT, 4, width of the repeat-count config
- BITS_BEATS, 16, width of the block-length config

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cfg_repeat_1  in  BITS_REPEAT  copies per beat minus 1; sampled only at block start
- cfg_beats_1  in  BITS_BEATS  input beats per block minus 1; sampled only at block start
- s_axis_tready  out  1  upstream ready
- s_axis_tvalid  in  1  upstream valid
- s_axis_pixels_1_tdata  in  WORD_WIDTH*UNITS  stream-1 pixels
- s_axis_pixels_2_tdata  in  WORD_WIDTH*UNITS  stream-2 pixels
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last copy of last beat of block
- m_axis_pixels_1_tdata  out  WORD_WIDTH*UNITS  stream-1 copy
- m_axis_pixels_2_tdata  out  WORD_WIDTH*UNITS  stream-2 copy

Behaviour:
- Reset (synchronous, areset=1 at a rising edge), regardless of state:
  - m_axis_tvalid=0, m_axis_tlast=0, both tdata=0.
  - rep_cnt=0, beat_cnt=0, blk_active=0; latched config cleared.
  - s_axis_tready=1 from the first cycle after reset.
  - A partially emitted block is discarded; nothing resumes.
- Definitions:
  - out_hs = m_axis_tvalid & m_axis_tready
  - in_hs = s_axis_tvalid & s_axis_tready
  - last_copy = (rep_cnt==0)
- Ready: s_axis_tready = !m_axis_tvalid | (out_hs_possible & last_copy), where out_hs_possible = m_axis_tready. It is combinational from m_axis_tready and registered state only, never from s_axis_tvalid.
- Accept (in_hs):
  - Load both tdata registers and set m_axis_tvalid=1 next cycle. Latency from in_hs to first copy is 1 cycle.
  - If blk_active=0: latch cfg_repeat_1 into rep_lat and cfg_beats_1 into beat_cnt, then set blk_active=1.
  - Otherwise decrement beat_cnt.
  - rep_cnt loads rep_lat (the freshly latched value on a block-start beat).
- Copy emission: on out_hs with !last_copy, rep_cnt decrements. Data holds; valid stays 1.
- On out_hs with last_copy:
  - If in_hs occurs in the same cycle, the new beat replaces the old with no bubble.
  - Otherwise m_axis_tvalid clears.
- tlast: m_axis_tlast = m_axis_tvalid & last_copy & (beat_cnt==0) & blk_active. Registered with the data path; it must not glitch on m_axis_tready.
- Block end: out_hs with tlast sets blk_active=0. A beat accepted in that same cycle starts a new block and samples the current config.
- Config changes while blk_active=1 have no effect until the next block start.
- Stalls: while m_axis_tready=0, tdata, tvalid and tlast are stable (AXIS rule). Counters hold.
- Width rules:
  - Copies per beat = cfg_repeat_1+1, range 1..2^BITS_REPEAT.
  - Beats per block = cfg_beats_1+1.
  - Output beats per block = (R+1)*(B+1).
  - Counters never wrap below 0; a count of 0 is the terminal state.
- Simultaneous in_hs and out_hs: both take effect in the same cycle with no loss or duplication. Throughput is 1 output per cycle at any R.

Decomposition:
- Shared package: pixel word width, UNITS, BITS_REPEAT, BITS_BEATS constants, plus the paired-pixel beat typedef (two UNITS×WORD_WIDTH arrays), reused by the input pipe.
- One natural sub-module: axis_pixel_repeat_ctrl, holding the counters, blk_active, ready/tlast logic. The top holds only the data registers.

Test Plan:
- cfg_repeat_1=2, cfg_beats_1=1; beats A,B sent back to back; m_axis_tready=1 -> outputs A,A,A,B,B,B on consecutive cycles; tlast only on the 6th; s_axis_tready low for 2 cycles after each accept.
- cfg_repeat_1=0, cfg_beats_1=3; continuous valid and ready -> one output per cycle, 1-cycle latency; tlast on 4th; s_axis_tready never drops.
- cfg_repeat_1=1; m_axis_tready toggled 1,0,0,1,… -> data and tlast stable during stalls; exactly 2 copies per beat; no dropped or extra beats versus a scoreboard.
- Change cfg_repeat_1 from 1 to 3 after the first beat of a 3-beat block -> the block emits 2 copies per beat; the next block emits 4 copies per beat.
- Assert areset after 3 output beats of a block -> next cycle m_axis_tvalid=0, tlast=0, tdata=0, s_axis_tready=1; a fresh block restarts with new config and correct tlast.
- Back-to-back blocks, cfg_beats_1=0, cfg_repeat_1=1 -> new beat accepted in the cycle of the tlast handshake; outputs X,X(tlast),Y,Y(tlast) with no bubble.
